// File: rtl/arr_check_driver.sv
`default_nettype none
// ============================================================================
//  Module      : arr_check_driver
//  Description : Stimulus driver for the arr sig/rfr checker: loads a pattern,
//                strobes check, waits for check_fb to clear, optionally
//                injects sig/rfr mismatches.
//  Revision    : 1.0
// ============================================================================
module arr_check_driver #(
    parameter int unsigned LENGTH         = 1,
    parameter int unsigned NUM_CHECKS     = 16,
    parameter int unsigned MISMATCH_EVERY = 0,
    parameter int unsigned TIMEOUT        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [LENGTH-1:0] sig,
    output logic [LENGTH-1:0] rfr,
    output logic              check,
    output logic              verbose,
    input  logic              verbose_en,
    input  logic              check_fb,
    output logic              busy,
    output logic              done,
    output logic [7:0]        strobe_count,
    output logic [7:0]        timeout_count
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_LOAD     = 3'd1;
    localparam logic [2:0] c_SETUP    = 3'd2;
    localparam logic [2:0] c_STROBE   = 3'd3;
    localparam logic [2:0] c_WAIT_CLR = 3'd4;
    localparam logic [2:0] c_NEXT     = 3'd5;
    localparam logic [2:0] c_DONE     = 3'd6;

    localparam logic [7:0] c_MUL     = 8'h5B;
    localparam logic [7:0] c_ADD     = 8'h3C;
    localparam logic [7:0] c_LAST    = 8'(NUM_CHECKS - 1);
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [7:0]        r_idx;
    logic [7:0]        r_timer;
    logic [LENGTH-1:0] r_sig;
    logic [LENGTH-1:0] r_rfr;
    logic              r_check;
    logic              r_verbose;
    logic              r_busy;
    logic              r_done;
    logic [7:0]        r_strobe_count;
    logic [7:0]        r_timeout_count;

    logic [7:0]        w_pat;
    logic [LENGTH-1:0] w_sig;
    logic [LENGTH-1:0] w_rfr;
    logic              w_inject;
    logic              w_last;
    logic              w_expire;
    logic              w_pat_unused;

    // Pattern is built in the 8-bit index domain, then tiled across LENGTH bits
    assign w_pat        = r_idx * c_MUL + c_ADD;
    assign w_pat_unused = ^w_pat;

    always_comb begin
        w_sig = '0;
        for (int i = 0; i < int'(LENGTH); i++) begin
            w_sig[i] = w_pat[i % 8];
        end
    end

    generate
        if (MISMATCH_EVERY == 0) begin : g_no_inject
            assign w_inject = 1'b0;
        end else begin : g_inject
            assign w_inject = ((32'(r_idx) + 32'd1) % MISMATCH_EVERY) == 32'd0;
        end
    endgenerate

    assign w_rfr    = w_sig ^ LENGTH'(w_inject);
    assign w_last   = (r_idx == c_LAST);
    // Timer holds the cycles still allowed; expiry is the last allowed high cycle
    assign w_expire = check_fb && (r_timer <= 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:     if (start) w_next = c_LOAD;
            c_LOAD:     w_next = c_SETUP;
            c_SETUP:    w_next = c_STROBE;
            c_STROBE:   w_next = c_WAIT_CLR;
            c_WAIT_CLR: if (!check_fb || w_expire) w_next = c_NEXT;
            c_NEXT:     w_next = w_last ? c_DONE : c_LOAD;
            c_DONE:     w_next = c_IDLE;
            default:    w_next = c_IDLE;
        endcase
    end

    // Strobe-type outputs are decoded from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx           <= 8'd0;
            r_timer         <= 8'd0;
            r_sig           <= '0;
            r_rfr           <= '0;
            r_check         <= 1'b0;
            r_verbose       <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_strobe_count  <= 8'd0;
            r_timeout_count <= 8'd0;
        end else begin
            r_verbose <= verbose_en;
            r_check   <= (w_next == c_STROBE);
            r_done    <= (w_next == c_DONE);
            r_busy    <= (w_next != c_IDLE);
            if (w_next == c_STROBE) begin
                r_strobe_count <= r_strobe_count + 8'd1;
            end
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_idx           <= 8'd0;
                        r_strobe_count  <= 8'd0;
                        r_timeout_count <= 8'd0;
                    end
                end
                c_LOAD: begin
                    r_sig <= w_sig;
                    r_rfr <= w_rfr;
                end
                c_STROBE: r_timer <= c_TIMEOUT;
                c_WAIT_CLR: begin
                    if (check_fb) begin
                        r_timer <= r_timer - 8'd1;
                    end
                    if (w_expire && (r_timeout_count != 8'hFF)) begin
                        r_timeout_count <= r_timeout_count + 8'd1;
                    end
                end
                c_NEXT: begin
                    if (!w_last) begin
                        r_idx <= r_idx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sig           = r_sig;
    assign rfr           = r_rfr;
    assign check         = r_check;
    assign verbose       = r_verbose;
    assign busy          = r_busy;
    assign done          = r_done;
    assign strobe_count  = r_strobe_count;
    assign timeout_count = r_timeout_count;

endmodule
`default_nettype wire

// File: tb/tb_arr_check_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arr_check_driver
//  Description : Self-checking bench for arr_check_driver (three parameter
//                sets, directed table, hand sequences, random runs).
//  Revision    : 1.0
// ============================================================================
module tb_arr_check_driver;

    logic clk = 1'b0;
    logic rst_n, start, verbose_en, fb;
    int   sel   = 0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Per-instance parameters: A, B, C
    int c_num[3] = '{4, 4, 6};
    int c_to[3]  = '{3, 8, 8};
    int c_mis[3] = '{2, 0, 3};
    int c_len[3] = '{8, 12, 1};

    int          h_q[16];
    int          meas_spacing;
    int          meas_to;
    logic [15:0] meas_sig0;
    logic [15:0] meas_rfr1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       w_st_a, w_st_b, w_st_c, w_fb_a, w_fb_b, w_fb_c;
    logic [7:0] sig_a, rfr_a, sc_a, tc_a, sc_b, tc_b, sc_c, tc_c;
    logic [11:0] sig_b, rfr_b;
    logic [0:0] sig_c, rfr_c;
    logic check_a, verbose_a, busy_a, done_a;
    logic check_b, verbose_b, busy_b, done_b;
    logic check_c, verbose_c, busy_c, done_c;

    assign w_st_a = start && (sel == 0);
    assign w_st_b = start && (sel == 1);
    assign w_st_c = start && (sel == 2);
    assign w_fb_a = fb && (sel == 0);
    assign w_fb_b = fb && (sel == 1);
    assign w_fb_c = fb && (sel == 2);

    arr_check_driver #(.LENGTH(8), .NUM_CHECKS(4), .MISMATCH_EVERY(2), .TIMEOUT(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(w_st_a), .sig(sig_a), .rfr(rfr_a),
        .check(check_a), .verbose(verbose_a), .verbose_en(verbose_en), .check_fb(w_fb_a),
        .busy(busy_a), .done(done_a), .strobe_count(sc_a), .timeout_count(tc_a));

    arr_check_driver #(.LENGTH(12), .NUM_CHECKS(4), .MISMATCH_EVERY(0), .TIMEOUT(8)) u_b (
        .clk(clk), .rst_n(rst_n), .start(w_st_b), .sig(sig_b), .rfr(rfr_b),
        .check(check_b), .verbose(verbose_b), .verbose_en(verbose_en), .check_fb(w_fb_b),
        .busy(busy_b), .done(done_b), .strobe_count(sc_b), .timeout_count(tc_b));

    arr_check_driver #(.LENGTH(1), .NUM_CHECKS(6), .MISMATCH_EVERY(3), .TIMEOUT(8)) u_c (
        .clk(clk), .rst_n(rst_n), .start(w_st_c), .sig(sig_c), .rfr(rfr_c),
        .check(check_c), .verbose(verbose_c), .verbose_en(verbose_en), .check_fb(w_fb_c),
        .busy(busy_c), .done(done_c), .strobe_count(sc_c), .timeout_count(tc_c));

    logic [15:0] sig_m, rfr_m;
    logic        check_m, verbose_m, busy_m, done_m;
    logic [7:0]  sc_m, tc_m;
    logic        w_any_a, w_any_all;

    always_comb begin
        case (sel)
            0: begin
                sig_m = 16'(sig_a); rfr_m = 16'(rfr_a); check_m = check_a; verbose_m = verbose_a;
                busy_m = busy_a; done_m = done_a; sc_m = sc_a; tc_m = tc_a;
            end
            1: begin
                sig_m = 16'(sig_b); rfr_m = 16'(rfr_b); check_m = check_b; verbose_m = verbose_b;
                busy_m = busy_b; done_m = done_b; sc_m = sc_b; tc_m = tc_b;
            end
            default: begin
                sig_m = 16'(sig_c); rfr_m = 16'(rfr_c); check_m = check_c; verbose_m = verbose_c;
                busy_m = busy_c; done_m = done_c; sc_m = sc_c; tc_m = tc_c;
            end
        endcase
    end

    assign w_any_a   = |{sig_a, rfr_a, check_a, verbose_a, busy_a, done_a, sc_a, tc_a};
    assign w_any_all = w_any_a |
                       (|{sig_b, rfr_b, check_b, verbose_b, busy_b, done_b, sc_b, tc_b}) |
                       (|{sig_c, rfr_c, check_c, verbose_c, busy_c, done_c, sc_c, tc_c});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference pattern: P(k) tiled bit by bit across len bits
    function automatic logic [15:0] model_sig(input int k, input int len);
        int          p;
        logic [15:0] r;
        p = (k * 91 + 60) % 256;
        r = '0;
        for (int i = 0; i < len; i++) r[i] = p[i % 8];
        return r;
    endfunction

    function automatic logic [15:0] model_rfr(input int k, input int len, input int mis);
        logic [15:0] r;
        r = model_sig(k, len);
        if (mis != 0 && ((k + 1) % mis) == 0) r[0] = ~r[0];
        return r;
    endfunction

    // One run on instance s; h_q[k] = cycles check_fb stays high from strobe k.
    // Strobe spacing = 4 + min(h, TIMEOUT); a timeout is counted when h > TIMEOUT.
    task automatic run(input int s, input bit hold_start, input bit rnd_verbose);
        int   num, tmo, k, rem, c0, last_s, exp_s, exp_done, exp_to, w, nbusy, h;
        bit   done_seen, again;
        logic prev_v;
        logic [15:0] prev_sig;
        num = c_num[s];
        tmo = c_to[s];
        sel = s;
        @(negedge clk);
        start = 1'b1;
        fb = 1'b0;
        c0 = cyc;
        k = 0; rem = 0; exp_s = c0 + 3; exp_done = 0; exp_to = 0; last_s = c0;
        nbusy = 0; done_seen = 0; again = 0;
        prev_v = verbose_en;
        prev_sig = sig_m;
        for (int t = 0; t < 1000 && !done_seen; t++) begin
            @(negedge clk);
            start = hold_start;
            chk("verbose", 32'(verbose_m), 32'(prev_v));
            if (rnd_verbose) verbose_en = 1'($urandom);
            prev_v = verbose_en;
            if (check_m) begin
                h = h_q[k % 16];
                chk("strobe_cycle", cyc, exp_s);
                chk("sig_setup", 32'(prev_sig), 32'(model_sig(k, c_len[s])));
                chk("sig", 32'(sig_m), 32'(model_sig(k, c_len[s])));
                chk("rfr", 32'(rfr_m), 32'(model_rfr(k, c_len[s], c_mis[s])));
                if (k == 0) meas_sig0 = sig_m;
                if (k == 1) begin
                    meas_rfr1 = rfr_m;
                    meas_spacing = cyc - last_s;
                end
                w = (h < tmo) ? h : tmo;
                if (h > tmo) exp_to++;
                last_s = cyc;
                exp_s = cyc + 4 + w;
                exp_done = cyc + w + 2;
                rem = h - 1;
                fb = 1'b1;
                k++;
            end else if (rem > 0) begin
                fb = 1'b1;
                rem--;
            end else begin
                fb = 1'b0;
            end
            if (done_m) begin
                done_seen = 1;
                chk("done_cycle", cyc, exp_done);
                chk("strobes_issued", k, num);
                chk("strobe_count", 32'(sc_m), num);
                chk("timeout_count", 32'(tc_m), exp_to);
                meas_to = int'(tc_m);
            end else if (!busy_m) begin
                nbusy++;
            end
            prev_sig = sig_m;
        end
        chk("run_finished", 32'(done_seen), 1);
        chk("busy_during_run", nbusy, 0);
        fb = 1'b0;
        if (hold_start) begin
            for (int t = 0; t < 40 && !again; t++) begin
                @(negedge clk);
                if (check_m) begin
                    again = 1;
                    chk("restart_cycle", cyc, exp_done + 4);
                end
            end
            chk("restart_seen", 32'(again), 1);
            start = 1'b0;
            done_seen = 0;
            for (int t = 0; t < 400 && !done_seen; t++) begin
                @(negedge clk);
                if (done_m) begin
                    done_seen = 1;
                    chk("rerun_strobe_count", 32'(sc_m), num);
                    chk("rerun_timeout_count", 32'(tc_m), 0);
                end
            end
            chk("rerun_finished", 32'(done_seen), 1);
        end
        start = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy_m), 0);
        chk("done_width", 32'(done_m), 0);
    endtask

    typedef struct {
        int          s;
        int          h;
        int          exp_spacing;
        int          exp_to;
        logic [15:0] exp_sig0;
        logic [15:0] exp_rfr1;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int cnt;
        int s;
        tbl[0] = '{0, 1,   5,  0, 16'h003C, 16'h0096};
        tbl[1] = '{0, 100, 7,  4, 16'h003C, 16'h0096};
        tbl[2] = '{1, 1,   5,  0, 16'h0C3C, 16'h0797};
        tbl[3] = '{1, 8,   12, 0, 16'h0C3C, 16'h0797};
        tbl[4] = '{1, 9,   12, 4, 16'h0C3C, 16'h0797};
        tbl[5] = '{2, 1,   5,  0, 16'h0000, 16'h0001};

        rst_n = 1'b0; start = 1'b0; verbose_en = 1'b0; fb = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'(w_any_all), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outs", 32'(w_any_all), 0);
        end

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 16; k++) h_q[k] = tbl[i].h;
            run(tbl[i].s, 1'b0, 1'b0);
            chk("tbl_spacing", meas_spacing, tbl[i].exp_spacing);
            chk("tbl_timeouts", meas_to, tbl[i].exp_to);
            chk("tbl_sig0", 32'(meas_sig0), 32'(tbl[i].exp_sig0));
            chk("tbl_rfr1", 32'(meas_rfr1), 32'(tbl[i].exp_rfr1));
        end

        // start held high through DONE chains straight into a second run
        for (int k = 0; k < 16; k++) h_q[k] = 1;
        run(0, 1'b1, 1'b1);

        // Reset during WAIT_CLR of strobe 2
        sel = 0;
        verbose_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        fb = 1'b1;
        cnt = 0;
        for (int t = 0; t < 100 && cnt < 2; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (check_m) cnt++;
        end
        chk("mid_reset_reach", cnt, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_clear", 32'(w_any_a), 0);
        repeat (3) begin
            @(negedge clk);
            chk("no_done_in_reset", 32'(done_m), 0);
        end
        rst_n = 1'b1;
        fb = 1'b0;
        run(0, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            s = int'($urandom_range(0, 2));
            for (int k = 0; k < 16; k++) h_q[k] = int'($urandom_range(1, c_to[s] + 2));
            run(s, 1'($urandom), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/arr_check_driver.md
Name: arr_check_driver

Overview:
Stimulus-side partner of the `arr` sig/rfr checker used in the VPI structure test designs.
- Loads a pattern onto `sig` and `rfr` and strobes `check`.
- Waits for the checker to consume the strobe, then steps to the next pattern.
- Can inject deliberate sig/rfr mismatches so the checker's `$stop` path can be exercised from HDL as well as from cocotb.
- One instance per `arr` instance, same LENGTH.

Parameters:
- LENGTH, 1: width of `sig` and `rfr`; must match the checker.
- NUM_CHECKS, 16: strobes issued per run; valid range 1..255.
- MISMATCH_EVERY, 0: inject a mismatch on every Nth strobe (1-based). 0 = never.
- TIMEOUT, 8: cycles allowed for `check_fb` to return low after a strobe; valid range 1..255.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: begin a run; sampled only in IDLE.
- sig, out, LENGTH: pattern to the checker.
- rfr, out, LENGTH: reference to the checker.
- check, out, 1: one-cycle strobe to the checker.
- verbose, out, 1: registered copy of `verbose_en`.
- verbose_en, in, 1: enables checker display.
- check_fb, in, 1: observed value of the checker's `check` net.
- busy, out, 1: high from the cycle after `start` is accepted until DONE.
- done, out, 1: one-cycle pulse when the run completes.
- strobe_count, out, 8: strobes issued in the current or last run.
- timeout_count, out, 8: strobes whose `check_fb` did not clear within TIMEOUT.

Behaviour:
- Reset (async assert, sync release): state=IDLE. sig, rfr, check, verbose, busy and done are all 0. strobe_count and timeout_count are 0. Internal idx=0.
- All outputs are registered.
- Pattern for index k, computed in an idx-width (8-bit) domain then reduced to LENGTH bits:
  - P(k) = (k * 8'h5B + 8'h3C) mod 256.
  - If LENGTH ≤ 8, sig = P(k) truncated to the low LENGTH bits.
  - If LENGTH > 8, sig = P(k) replicated, truncated to LENGTH bits.
- Mismatch injection: rfr = sig, except when MISMATCH_EVERY≠0 and (k+1) mod MISMATCH_EVERY == 0. In that case rfr = sig with bit 0 inverted.
- States and transitions:
  - IDLE:
    - `start`=1 → LOAD.
    - In the same cycle: idx←0, strobe_count←0, timeout_count←0, busy←1.
  - LOAD: sig/rfr ← pattern(idx) → SETUP.
  - SETUP:
    - Hold sig/rfr for one cycle (setup margin) → STROBE.
    - check is still 0.
  - STROBE:
    - check←1 for exactly one cycle; strobe_count←strobe_count+1.
    - Load the timeout counter with TIMEOUT → WAIT_CLR.
  - WAIT_CLR:
    - check←0.
    - `check_fb`=0 → NEXT.
    - Otherwise decrement the timer. On reaching 0: timeout_count←timeout_count+1 (saturating at 255) → NEXT.
  - NEXT:
    - If idx == NUM_CHECKS-1: go to DONE.
    - Otherwise idx←idx+1 and go to LOAD.
  - DONE:
    - done←1 for one cycle; busy←0 → IDLE.
    - sig/rfr keep their last values.
- Cycle timing: one strobe every 5 cycles when `check_fb` clears immediately. The first `check` rises 3 cycles after `start` is sampled.
- `start` while not in IDLE is ignored. `start` held high through DONE begins a new run on the next IDLE cycle.
- sig/rfr change only in LOAD. They are stable from SETUP through WAIT_CLR.
- `verbose` follows `verbose_en` with 1-cycle latency in every state.
- Reset mid-run: immediate return to reset values, no done pulse. The next run starts from idx=0.
- `check_fb` high on entry to WAIT_CLR (checker slow or absent) is a normal condition, not an error. It is counted only on timeout.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst_n=0 3 cycles, release, wait 10 cycles with start=0.
  - Required: all outputs 0, busy=0, no check pulses.
- Basic run, LENGTH=8, NUM_CHECKS=4, MISMATCH_EVERY=0, check_fb tied to check delayed by 0:
  - Required check pulses at cycles 3, 8, 13 and 18 after start.
  - Required sig=rfr = 8'h3C, 8'h97, 8'hF2, 8'h4D.
  - Required done pulse, strobe_count=4, timeout_count=0.
- Mismatch injection, LENGTH=8, MISMATCH_EVERY=2, NUM_CHECKS=4, paired with a real `arr` checker:
  - Required strobes 2 and 4 have rfr = sig^1 (8'h96 and 8'h4C), and the checker reaches `$stop` on strobe 2.
- Timeout, TIMEOUT=3, check_fb tied to 1:
  - Required each strobe spacing grows to 7 cycles.
  - Required timeout_count=NUM_CHECKS at done.
- Reset mid-run:
  - Stimulus: assert rst_n low during WAIT_CLR of strobe 2, release, start again.
  - Required: outputs clear asynchronously, no done pulse, first sig after restart = pattern(0).
- LENGTH=1 and LENGTH=12:
  - Required LENGTH=1: sig sequence 0, 1, 0, 1 (low bit of P(k)).
  - Required LENGTH=12: first sig = 12'hC3C.
